sample_pair_loader: RTL and testbench

//  Input stage directly upstream of address_order. Accepts a stream of complex

---
 rtl/fft_pkg.sv | 18 +
 rtl/sample_pair_loader.sv | 127 ++++++++++++
 tb/tb_sample_pair_loader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types for the FFT input path: loader FSM states and the complex sample record.
package fft_pkg;

    localparam int FFT_DATA_W = 10;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } loader_state_t;

    // Field names avoid the 'real' keyword.
    typedef struct packed {
        logic [FFT_DATA_W-1:0] re;
        logic [FFT_DATA_W-1:0] im;
    } complex_sample_t;

endpackage

// File: rtl/sample_pair_loader.sv
// Pairs an incoming complex sample stream into butterfly operands a/b and holds
// each full frame until the downstream stage acknowledges it.
module sample_pair_loader
    import fft_pkg::*;
#(
    parameter int DATA_W        = FFT_DATA_W,
    parameter int FRAME_SAMPLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_real,
    input  logic [DATA_W-1:0]   in_imag,
    input  logic                flush,
    input  logic                frame_ack,
    output logic [DATA_W-1:0]   a_real,
    output logic [DATA_W-1:0]   a_imag,
    output logic [DATA_W-1:0]   b_real,
    output logic [DATA_W-1:0]   b_imag,
    output logic                pair_valid,
    output logic [CNT_W-1:0]    samples_loaded_count,
    output logic                frame_done,
    output loader_state_t       dbg_state
);

    if ((FRAME_SAMPLES < 2) || ((FRAME_SAMPLES % 2) != 0) || (FRAME_SAMPLES >= (1 << CNT_W))) begin : g_bad_cfg
        $error("sample_pair_loader: FRAME_SAMPLES must be even, >= 2 and < 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_SAMPLES - 1);

    loader_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  a_re_q, a_re_d, a_im_q, a_im_d;
    logic [DATA_W-1:0]  b_re_q, b_re_d, b_im_q, b_im_d;
    logic               pair_valid_q, pair_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               accept;

    // Handshake: a sample transfers on a rising edge where in_valid and in_ready are both 1.
    assign accept = in_valid & in_ready_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = LOAD_A;
        end else begin
            unique case (state_q)
                LOAD_A:  if (accept) state_d = LOAD_B;
                LOAD_B:  if (accept) state_d = (cnt_q == LAST_IDX) ? FULL : LOAD_A;
                FULL:    if (frame_ack) state_d = LOAD_A;
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        a_re_d       = a_re_q;
        a_im_d       = a_im_q;
        b_re_d       = b_re_q;
        b_im_d       = b_im_q;
        pair_valid_d = 1'b0;
        in_ready_d   = (state_d != FULL);
        if (flush) begin
            cnt_d  = '0;
            a_re_d = '0;
            a_im_d = '0;
            b_re_d = '0;
            b_im_d = '0;
        end else if ((state_q == FULL) && frame_ack) begin
            cnt_d = '0;
        end else if (accept) begin
            // in_ready is low throughout FULL, so an accept only happens in LOAD_A or LOAD_B.
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == LOAD_A) begin
                a_re_d = in_real;
                a_im_d = in_imag;
            end else begin
                b_re_d       = in_real;
                b_im_d       = in_imag;
                pair_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q        <= '0;
            a_re_q       <= '0;
            a_im_q       <= '0;
            b_re_q       <= '0;
            b_im_q       <= '0;
            pair_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            a_re_q       <= a_re_d;
            a_im_q       <= a_im_d;
            b_re_q       <= b_re_d;
            b_im_q       <= b_im_d;
            pair_valid_q <= pair_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready             = in_ready_q;
    assign a_real               = a_re_q;
    assign a_imag               = a_im_q;
    assign b_real               = b_re_q;
    assign b_imag               = b_im_q;
    assign pair_valid           = pair_valid_q;
    assign samples_loaded_count = cnt_q;
    assign frame_done           = (state_q == FULL);
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_sample_pair_loader.sv
// Bench for sample_pair_loader: directed steps then random traffic, checked
// against a frame-level model kept as a list of accepted samples.
module tb_sample_pair_loader;
    import fft_pkg::*;

    localparam int DW = 10;
    localparam int FS = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_real = '0;
    logic [DW-1:0] in_imag = '0;
    logic          flush = 1'b0;
    logic          frame_ack = 1'b0;
    logic [DW-1:0] a_real, a_imag, b_real, b_imag;
    logic          pair_valid;
    logic [CW-1:0] samples_loaded_count;
    logic          frame_done;
    loader_state_t dbg_state;

    int errors = 0;
    int checks = 0;

    // Model: samples accepted into the current frame, latest a/b, and the outputs.
    logic [2*DW-1:0] frame_q[$];
    int              m_a_re, m_a_im, m_b_re, m_b_im;
    bit              m_pv, m_full, m_ready;

    sample_pair_loader #(.DATA_W(DW), .FRAME_SAMPLES(FS), .CNT_W(CW)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .flush(flush), .frame_ack(frame_ack),
        .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
        .pair_valid(pair_valid), .samples_loaded_count(samples_loaded_count),
        .frame_done(frame_done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        frame_q.delete();
        m_a_re = 0; m_a_im = 0; m_b_re = 0; m_b_im = 0;
        m_pv = 0; m_full = 0; m_ready = 0;
    endtask

    task automatic model_step(input bit v, input int re, input int im, input bit fl, input bit ack);
        int idx;
        m_pv = 0;
        if (fl) begin
            frame_q.delete();
            m_a_re = 0; m_a_im = 0; m_b_re = 0; m_b_im = 0;
            m_full = 0;
        end else if (m_full) begin
            if (ack) begin
                m_full = 0;
                frame_q.delete();
            end
        end else if (v && m_ready) begin
            idx = frame_q.size();
            frame_q.push_back({re[DW-1:0], im[DW-1:0]});
            if (idx % 2 == 0) begin
                m_a_re = re; m_a_im = im;
            end else begin
                m_b_re = re; m_b_im = im; m_pv = 1;
            end
            if (frame_q.size() == FS) m_full = 1;
        end
        m_ready = !m_full;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string ph);
        int exp_state;
        exp_state = m_full ? int'(FULL) : ((frame_q.size() % 2 == 1) ? int'(LOAD_B) : int'(LOAD_A));
        chk({ph, ".in_ready"}, 32'(in_ready), 32'(m_ready));
        chk({ph, ".a_real"}, 32'(a_real), 32'(m_a_re));
        chk({ph, ".a_imag"}, 32'(a_imag), 32'(m_a_im));
        chk({ph, ".b_real"}, 32'(b_real), 32'(m_b_re));
        chk({ph, ".b_imag"}, 32'(b_imag), 32'(m_b_im));
        chk({ph, ".pair_valid"}, 32'(pair_valid), 32'(m_pv));
        chk({ph, ".count"}, 32'(samples_loaded_count), 32'(frame_q.size()));
        chk({ph, ".frame_done"}, 32'(frame_done), 32'(m_full));
        chk({ph, ".state"}, 32'(dbg_state), 32'(exp_state));
    endtask

    // Inputs are applied 1 time unit after a rising edge; outputs checked 1 unit after the next.
    task automatic step(input string ph, input bit v, input int re, input int im,
                        input bit fl = 0, input bit ack = 0);
        in_valid  = v;
        in_real   = re[DW-1:0];
        in_imag   = im[DW-1:0];
        flush     = fl;
        frame_ack = ack;
        @(posedge clk);
        model_step(v, re, im, fl, ack);
        #1;
        compare_all(ph);
    endtask

    initial begin
        // 1: reset
        model_reset();
        #3;
        compare_all("reset");
        @(posedge clk); #1;
        nrst = 1'b1;
        step("rel", 0, 0, 0);
        chk("rel.ready_lit", 32'(in_ready), 32'd1);

        // 2: one full frame back-to-back
        step("ld1", 1, 1, 10);
        step("ld2", 1, 128, 511);
        chk("ld2.pv_lit", 32'(pair_valid), 32'd1);
        step("ld3", 1, 3, 4);
        step("ld4", 1, 5, 6);
        chk("ld4.a_lit", 32'({a_real, a_imag}), 32'({10'd3, 10'd4}));
        chk("ld4.b_lit", 32'({b_real, b_imag}), 32'({10'd5, 10'd6}));
        chk("ld4.done_lit", 32'({frame_done, in_ready}), 32'd2);

        // 3: hold full frame, then ack with a sample that must not be taken
        for (int i = 0; i < 5; i++) step("hold", 1, 7, 8);
        step("ack", 1, 9, 9, 0, 1);
        chk("ack.count_lit", 32'(samples_loaded_count), 32'd0);
        step("post_ack", 1, 9, 9);
        chk("post_ack.a_lit", 32'({a_real, a_imag}), 32'({10'd9, 10'd9}));

        // 4: gapped input
        step("gap", 0, 0, 0);
        step("gap", 1, 20, 21);
        step("gap", 0, 0, 0);
        step("gap", 0, 0, 0);
        step("gap", 1, 22, 23);
        step("gap", 0, 0, 0);
        step("gap", 1, 24, 25, 0, 1);
        step("gap", 0, 0, 0, 0, 1);

        // 5: flush after 3 samples of a fresh frame
        step("fl_pre", 1, 30, 31);
        step("fl_pre", 1, 32, 33);
        step("fl_pre", 1, 34, 35);
        step("flush", 1, 36, 37, 1);
        chk("flush.a_lit", 32'(a_real), 32'd0);
        step("fl_post", 1, 38, 39);
        chk("fl_post.a_lit", 32'(a_real), 32'd38);

        // 6: frame_ack in LOAD_B is ignored
        step("ackb", 0, 0, 0, 0, 1);
        step("ackb", 0, 0, 0, 0, 1);

        // Reset in the middle of a frame
        step("mid", 1, 40, 41);
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        compare_all("midrst");
        @(posedge clk); #1;
        nrst = 1'b1;
        step("midrel", 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
